// File: rtl/i2s_rx.sv
// I2S serial-input deserializer in the mck domain; bck/lrck/sdin are sampled as synchronous inputs.
// Define I2S_RX_LEFT_JUST_EN for left-justified framing (MSB on the boundary bck, no delay bit).
module i2s_rx #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SLOT_W = 32
) (
  input  logic              mck,
  input  logic              reset,
  input  logic              bck,
  input  logic              lrck,
  input  logic              sdin,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              valid,
  input  logic              ready,
  output logic              overrun
);

  localparam int unsigned CntW = $clog2(SLOT_W) + 1;
  localparam int unsigned PosW = CntW + 1;
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
`ifdef I2S_RX_LEFT_JUST_EN
  localparam int unsigned CapOff = 1;
`else
  localparam int unsigned CapOff = 0;
`endif

  typedef enum logic [1:0] {StSync, StLeft, StRight} state_e;

  state_e              state_q;
  logic                bck_r_q, bck_r2_q, lrck_r_q, sdin_r_q, lrck_prev_q;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   left_hold_q, left_data_q, right_data_q;
  logic                valid_q, overrun_q;
  logic                bck_rise, boundary;
  logic [PosW-1:0]     pos;
  logic [IdxW-1:0]     cap_idx;

  always_comb begin
    bck_rise  = bck_r_q & ~bck_r2_q;
    boundary  = bck_rise & (lrck_r_q ^ lrck_prev_q);
    bit_cnt_d = bit_cnt_q;
    if (boundary) begin
      bit_cnt_d = '0;
    end else if (bck_rise && (bit_cnt_q < CntW'(SLOT_W))) begin
      bit_cnt_d = bit_cnt_q + CntW'(1);
    end
    // pos is the 1-based data bit index (1 = MSB) of the bit sampled in this bck_rise
    pos     = {1'b0, bit_cnt_d} + PosW'(CapOff);
    cap_idx = IdxW'(PosW'(DATA_W) - pos);
    // Clearing on the boundary gives zero-fill for slots shorter than DATA_W
    shift_d = boundary ? '0 : shift_q;
    if (bck_rise && (pos != '0) && (pos <= PosW'(DATA_W))) begin
      shift_d[cap_idx] = sdin_r_q;
    end
  end

  always_ff @(posedge mck or posedge reset) begin
    if (reset) begin
      state_q      <= StSync;
      bck_r_q      <= 1'b0;
      bck_r2_q     <= 1'b0;
      lrck_r_q     <= 1'b0;
      sdin_r_q     <= 1'b0;
      lrck_prev_q  <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_data_q  <= '0;
      right_data_q <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bck_r_q   <= bck;
      bck_r2_q  <= bck_r_q;
      lrck_r_q  <= lrck;
      sdin_r_q  <= sdin;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      overrun_q <= 1'b0;
      if (bck_rise) begin
        lrck_prev_q <= lrck_r_q;
      end
      if (valid_q && ready) begin
        valid_q <= 1'b0;
      end
      if (boundary) begin
        case (state_q)
          StSync: begin
            if (!lrck_r_q) begin
              state_q <= StLeft;
            end
          end
          StLeft: begin
            if (lrck_r_q) begin
              left_hold_q <= shift_q;
              state_q     <= StRight;
            end
          end
          StRight: begin
            if (!lrck_r_q) begin
              if (!valid_q || ready) begin
                left_data_q  <= left_hold_q;
                right_data_q <= shift_q;
                valid_q      <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
              state_q <= StLeft;
            end
          end
          default: state_q <= StSync;
        endcase
      end
    end
  end

  assign left_data  = left_data_q;
  assign right_data = right_data_q;
  assign valid      = valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: random slot contents checked against a slot-level word model.
// Build with I2S_RX_LEFT_JUST_EN defined to exercise the left-justified variant.
module tb_i2s_rx;

  localparam int DW = 24;
  localparam int SW = 32;

  logic          mck = 1'b0;
  logic          reset, bck, lrck, sdin, ready;
  logic [DW-1:0] left_data, right_data;
  logic          valid, overrun;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int hs_cnt = 0;
  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] exp_pair;

  always #5 mck = ~mck;

  i2s_rx #(.DATA_W(DW), .SLOT_W(SW)) dut (
    .mck       (mck),
    .reset     (reset),
    .bck       (bck),
    .lrck      (lrck),
    .sdin      (sdin),
    .left_data (left_data),
    .right_data(right_data),
    .valid     (valid),
    .ready     (ready),
    .overrun   (overrun)
  );

  // Every accepted pair must be the next one the model expects
  always @(negedge mck) begin
    if (!reset) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (valid === 1'b1 && ready === 1'b1) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL handshake_unexpected: got L=%h R=%h, required no pair",
                   left_data, right_data);
        end else begin
          exp_pair = exp_q.pop_front();
          if ({left_data, right_data} !== exp_pair) begin
            errors++;
            $display("FAIL handshake_data: got L=%h R=%h, required L=%h R=%h",
                     left_data, right_data, exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
          end
        end
      end
    end
  end

  // Slot bits are MSB-aligned: bits[31] is sent on the boundary bck.
  function automatic logic [31:0] fmt_word(input logic [DW-1:0] w);
`ifdef I2S_RX_LEFT_JUST_EN
    return {w, 8'h00};
`else
    return {1'b0, w, 7'h00};
`endif
  endfunction

  // Word the receiver should produce for a slot of len bck carrying bits
  function automatic logic [DW-1:0] model_word(input logic [31:0] bits, input int len);
    logic [31:0] v;
    v = bits & ~(32'hFFFF_FFFF >> len);
`ifdef I2S_RX_LEFT_JUST_EN
    return v[31:8];
`else
    return v[30:7];
`endif
  endfunction

  task automatic drive_bit(input logic lr, input logic d);
    bck = 1'b0; lrck = lr; sdin = d;
    repeat (2) @(posedge mck);
    #1 bck = 1'b1;
    repeat (2) @(posedge mck);
    #1;
  endtask

  task automatic send_slot(input logic lr, input logic [31:0] bits, input int len);
    logic [31:0] b;
    b = bits;
    for (int p = 0; p < len; p++) begin
      drive_bit(lr, b[31]);
      b = b << 1;
    end
  endtask

  task automatic send_frame(input logic [31:0] lb, input int ll, input logic [31:0] rb,
                            input int rl, input bit expect_out);
    send_slot(1'b0, lb, ll);
    send_slot(1'b1, rb, rl);
    if (expect_out) exp_q.push_back({model_word(lb, ll), model_word(rb, rl)});
  endtask

  task automatic apply_reset();
    reset = 1'b1; bck = 1'b0; lrck = 1'b0; sdin = 1'b0;
    repeat (3) @(posedge mck);
    #1 reset = 1'b0;
    @(posedge mck);
    #1;
  endtask

  task automatic preamble();
    send_slot(1'b1, $urandom, 6);
  endtask

  task automatic close_and_drain(input string name);
    send_slot(1'b0, 32'h0, 4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d pairs still pending, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    ready = 1'b1;
    reset = 1'b1; bck = 1'b0; lrck = 1'b0; sdin = 1'b0;
    repeat (2) @(posedge mck);
    @(negedge mck);
    checks += 2;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b overrun=%b, required 0 0", valid, overrun);
    end
    if (left_data !== '0 || right_data !== '0) begin
      errors++;
      $display("FAIL reset_data: got L=%h R=%h, required 0 0", left_data, right_data);
    end
    @(posedge mck);
    #1 reset = 1'b0;
    preamble();
    send_slot(1'b0, $urandom, 32);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_early_pair: got valid=%b, required 0", valid);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    ready = 1'b1;
    preamble();
    send_slot(1'b0, fmt_word(24'hA5A5A5), 32);
    send_slot(1'b1, fmt_word(24'h5A5A5A), 32);
    exp_q.push_back({24'hA5A5A5, 24'h5A5A5A});
    bck = 1'b0; lrck = 1'b0; sdin = 1'b0;
    repeat (2) @(posedge mck);
    #1 bck = 1'b1;
    @(posedge mck);
    @(negedge mck);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: got valid=%b in bck_rise cycle, required 0", valid);
    end
    @(posedge mck);
    @(negedge mck);
    checks++;
    if (valid !== 1'b1 || left_data !== 24'hA5A5A5 || right_data !== 24'h5A5A5A) begin
      errors++;
      $display("FAIL basic_pair: got valid=%b L=%h R=%h, required 1 A5A5A5 5A5A5A",
               valid, left_data, right_data);
    end
    @(posedge mck);
    @(negedge mck);
    checks++;
    if (valid !== 1'b0 || left_data !== 24'hA5A5A5) begin
      errors++;
      $display("FAIL basic_after_accept: got valid=%b L=%h, required 0 A5A5A5", valid, left_data);
    end
    @(posedge mck);
    #1;
    close_and_drain("basic");
  endtask

  task automatic test_stream();
    int ovr0, hs0, ll, rl;
    logic [DW-1:0] n;
    apply_reset();
    ready = 1'b1;
    ovr0 = ovr_cnt; hs0 = hs_cnt;
    preamble();
    for (int i = 1; i <= 4; i++) begin
      n = DW'(i);
      send_frame(fmt_word(n), 32, fmt_word(~n), 32, 1'b1);
    end
    for (int i = 0; i < 4; i++) begin
      ll = $urandom_range(8, SW);
      rl = $urandom_range(8, SW);
      send_frame($urandom, ll, $urandom, rl, 1'b1);
    end
    close_and_drain("stream");
    checks += 2;
    if (hs_cnt - hs0 != 8) begin
      errors++;
      $display("FAIL stream_count: got %0d pairs, required 8", hs_cnt - hs0);
    end
    if (ovr_cnt != ovr0) begin
      errors++;
      $display("FAIL stream_overrun: got %0d pulses, required 0", ovr_cnt - ovr0);
    end
  endtask

  task automatic test_backpressure();
    int ovr0;
    logic [DW-1:0] l1, r1;
    apply_reset();
    ready = 1'b0;
    ovr0 = ovr_cnt;
    l1 = DW'($urandom); r1 = DW'($urandom);
    preamble();
    send_frame(fmt_word(l1), 32, fmt_word(r1), 32, 1'b1);
    send_frame($urandom, 32, $urandom, 32, 1'b0);
    checks++;
    if (valid !== 1'b1 || left_data !== l1 || right_data !== r1 || ovr_cnt - ovr0 != 0) begin
      errors++;
      $display("FAIL bp_first_held: got valid=%b L=%h R=%h ovr=%0d, required 1 %h %h 0",
               valid, left_data, right_data, ovr_cnt - ovr0, l1, r1);
    end
    send_frame($urandom, 32, $urandom, 32, 1'b0);
    checks++;
    if (ovr_cnt - ovr0 != 1) begin
      errors++;
      $display("FAIL bp_overrun_f2: got %0d pulses, required 1", ovr_cnt - ovr0);
    end
    send_slot(1'b0, 32'h0, 4);
    checks++;
    if (ovr_cnt - ovr0 != 2 || valid !== 1'b1 || left_data !== l1 || right_data !== r1) begin
      errors++;
      $display("FAIL bp_overrun_f3: got ovr=%0d valid=%b L=%h R=%h, required 2 1 %h %h",
               ovr_cnt - ovr0, valid, left_data, right_data, l1, r1);
    end
    ready = 1'b1;
    @(posedge mck);
    @(negedge mck);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_valid_drop: got valid=%b, required 0", valid);
    end
    @(posedge mck);
    #1;
    close_and_drain("bp");
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] la, ra, ld, rd;
    apply_reset();
    ready = 1'b1;
    la = DW'($urandom); ra = DW'($urandom); ld = DW'($urandom); rd = DW'($urandom);
    preamble();
    send_frame(fmt_word(la), 32, fmt_word(ra), 32, 1'b1);
    send_slot(1'b0, $urandom, 32);
    send_slot(1'b1, $urandom, 12);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rmid_first_pair: %0d pending, required 0", exp_q.size());
    end
    reset = 1'b1;
    @(negedge mck);
    checks++;
    if (valid !== 1'b0 || left_data !== '0 || right_data !== '0) begin
      errors++;
      $display("FAIL rmid_reset_state: got valid=%b L=%h R=%h, required 0 0 0",
               valid, left_data, right_data);
    end
    @(posedge mck);
    #1 reset = 1'b0;
    send_slot(1'b1, $urandom, 20);
    send_frame(fmt_word(ld), 32, fmt_word(rd), 32, 1'b1);
    close_and_drain("rmid");
  endtask

  task automatic test_short_slot();
    logic [DW-1:0] r;
    apply_reset();
    ready = 1'b1;
    r = DW'($urandom);
    preamble();
    send_slot(1'b0, 32'hFFFF_0000, 16);
    send_slot(1'b1, fmt_word(r), 32);
`ifdef I2S_RX_LEFT_JUST_EN
    exp_q.push_back({24'hFFFF00, r});
`else
    exp_q.push_back({24'hFFFE00, r});
`endif
    close_and_drain("short_slot");
  endtask

  task automatic test_boundary_bit();
    logic [DW-1:0] r;
    apply_reset();
    ready = 1'b1;
    r = DW'($urandom);
    preamble();
    send_slot(1'b0, 32'h8000_0000, 32);
    send_slot(1'b1, fmt_word(r), 32);
`ifdef I2S_RX_LEFT_JUST_EN
    exp_q.push_back({24'h800000, r});
`else
    exp_q.push_back({24'h000000, r});
`endif
    close_and_drain("boundary_bit");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; bck = 1'b0; lrck = 1'b0; sdin = 1'b0; ready = 1'b1;
    test_reset();
    test_basic();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_short_slot();
    test_boundary_bit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
